// File: rtl/fact_host.sv
// -----------------------------------------------------------------------------
// fact_host
//
// Initiator-side front end for the factorial accelerator. The MIPS core sees a
// 4-word register window (N, CTRL, STATUS, RESULT). A GO write launches one
// transaction: the block pulses Go for one cycle, then waits for Done and
// captures Result/Error. A cycle-count timeout aborts the wait if the
// accelerator never answers.
//
// Optional build macro: FACT_HOST_IRQ_EN
//   When defined, an interrupt enable bit (CTRL bit 1) and an IRQ output
//   (done & ien) are added. A=1 then reads {ien, Busy}.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   WE      in   bus write enable
//   A       in   word address: 0=N, 1=CTRL, 2=STATUS, 3=RESULT
//   WD      in   bus write data
//   RD      out  bus read data, combinational from A
//   Go      out  one-cycle start strobe to the accelerator
//   N       out  operand to the accelerator
//   Done    in   accelerator completion pulse
//   Error   in   accelerator overflow flag (may pulse before Done)
//   Result  in   accelerator product, valid while Done=1
//   Busy    out  high while a transaction is in flight
//   IRQ     out  (FACT_HOST_IRQ_EN only) done & ien
// -----------------------------------------------------------------------------
module fact_host #(
    parameter int DATA_W      = 32,
    parameter int N_W         = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WE,
    input  logic [1:0]        A,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD,
    output logic              Go,
    output logic [N_W-1:0]    N,
    input  logic              Done,
    input  logic              Error,
    input  logic [DATA_W-1:0] Result,
    output logic              Busy
`ifdef FACT_HOST_IRQ_EN
    ,
    output logic              IRQ
`endif
);

    // One extra bit so the counter can never wrap inside a transaction.
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_W-1:0]      n_q, n_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                tmo_q, tmo_d;
    logic                err_seen_q, err_seen_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                go_q, go_d;
`ifdef FACT_HOST_IRQ_EN
    logic                ien_q, ien_d;
`endif

    logic wr_n, wr_ctrl, wr_stat;
    logic unused_wd;

    assign wr_n    = WE && (A == 2'd0);
    assign wr_ctrl = WE && (A == 2'd1);
    assign wr_stat = WE && (A == 2'd2);

    // Only the low bits of the bus word carry meaning for this block.
    assign unused_wd = ^WD;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        result_d   = result_q;
        done_d     = done_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        err_seen_d = err_seen_q;
        timer_d    = timer_q;
`ifdef FACT_HOST_IRQ_EN
        ien_d      = ien_q;
        // Interrupt enable is writable even mid-transaction.
        if (wr_ctrl) begin
            ien_d = WD[1];
        end
`endif

        // W1C is applied first so that a Done capture in the same cycle
        // (below) overrides it.
        if (wr_stat) begin
            if (WD[0]) done_d = 1'b0;
            if (WD[1]) err_d  = 1'b0;
            if (WD[2]) tmo_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_n) begin
                    n_d = WD[N_W-1:0];
                end
                if (wr_ctrl && WD[0]) begin
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    tmo_d      = 1'b0;
                    err_seen_d = 1'b0;
                    timer_d    = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (Error) begin
                    err_seen_d = 1'b1;
                end
                // Done takes priority over a timeout landing in the same cycle.
                if (Done) begin
                    result_d = Result;
                    done_d   = 1'b1;
                    err_d    = err_seen_q | Error;
                    state_d  = S_IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Go is registered: high exactly while the FSM sits in START.
        go_d = (state_d == S_START);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            err_seen_q <= 1'b0;
            timer_q    <= '0;
            go_q       <= 1'b0;
`ifdef FACT_HOST_IRQ_EN
            ien_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            result_q   <= result_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            err_seen_q <= err_seen_d;
            timer_q    <= timer_d;
            go_q       <= go_d;
`ifdef FACT_HOST_IRQ_EN
            ien_q      <= ien_d;
`endif
        end
    end

    assign Go   = go_q;
    assign N    = n_q;
    assign Busy = (state_q != S_IDLE);
`ifdef FACT_HOST_IRQ_EN
    assign IRQ  = done_q & ien_q;
`endif

    always_comb begin
        RD = '0;
        case (A)
            2'd0: RD[N_W-1:0] = n_q;
            2'd1: begin
                RD[0] = Busy;
`ifdef FACT_HOST_IRQ_EN
                RD[1] = ien_q;
`endif
            end
            2'd2: RD[2:0] = {tmo_q, err_q, done_q};
            default: RD = result_q;
        endcase
    end

endmodule

// File: tb/tb_fact_host.sv
// -----------------------------------------------------------------------------
// tb_fact_host
//
// Self-checking bench for fact_host. A small accelerator model answers each
// Go pulse after a programmable number of WAIT cycles (or never), optionally
// pulsing Error some cycles before Done. Expected register contents come from
// a transaction-level model: busy length, STATUS and RESULT per transaction.
// -----------------------------------------------------------------------------
module tb_fact_host;

    localparam int DATA_W      = 32;
    localparam int N_W         = 4;
    localparam int TIMEOUT_CYC = 64;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [1:0]        a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic              go;
    logic [N_W-1:0]    n_o;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] result;
    logic              busy;
`ifdef FACT_HOST_IRQ_EN
    logic              irq;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    fact_host #(
        .DATA_W     (DATA_W),
        .N_W        (N_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .WE    (we),
        .A     (a),
        .WD    (wd),
        .RD    (rd),
        .Go    (go),
        .N     (n_o),
        .Done  (done),
        .Error (error),
        .Result(result),
        .Busy  (busy)
`ifdef FACT_HOST_IRQ_EN
        ,
        .IRQ   (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- accelerator model ----------------
    int          acc_lat     = 10;
    logic [31:0] acc_res     = 0;
    int          acc_err_off = -1;
    bit          acc_hang    = 0;
    bit          acc_active  = 0;
    int          acc_cnt     = 0;
    logic        acc_done    = 1'b0;
    logic        acc_err     = 1'b0;
    logic        man_done    = 1'b0;
    logic        man_err     = 1'b0;

    assign done  = acc_done | man_done;
    assign error = acc_err | man_err;

    // acc_cnt = index of the WAIT cycle currently in progress (1-based).
    always begin
        @(posedge clk);
        if (!rst_n) begin
            acc_active = 0;
        end else if (go) begin
            acc_active = 1;
            acc_cnt    = 1;
        end else if (acc_active) begin
            if ((!acc_hang && acc_cnt == acc_lat) || acc_cnt >= TIMEOUT_CYC + 2)
                acc_active = 0;
            else
                acc_cnt++;
        end
        #1;
        acc_done = acc_active && !acc_hang && (acc_cnt == acc_lat);
        acc_err  = acc_active && (acc_err_off >= 0) && (acc_cnt == acc_lat - acc_err_off);
        result   = acc_done ? acc_res : $urandom();
    end

    // ---------------- helpers ----------------
    typedef struct {
        int          n;
        int          lat;
        logic [31:0] res;
        int          err_off;
        bit          hang;
        int          exp_busy;
        logic [2:0]  exp_stat;
        logic [31:0] exp_res;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive at posedge+1, sampled at next posedge, return at posedge+1.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = '0;
    endtask

    task automatic rd_chk(input logic [1:0] addr, input logic [31:0] exp, input string nm);
        a = addr;
        @(negedge clk);
        chk(nm, rd, exp);
    endtask

    task automatic set_acc(input int lat, input logic [31:0] res, input int eo, input bit hang);
        acc_lat     = lat;
        acc_res     = res;
        acc_err_off = eo;
        acc_hang    = hang;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int busy_cnt, go_cnt, n_bad;
        set_acc(v.lat, v.res, v.err_off, v.hang);
        bus_write(2'd0, 32'(v.n));
        bus_write(2'd1, 32'd1);
        busy_cnt = 0;
        go_cnt   = 0;
        n_bad    = 0;
        while (busy && busy_cnt < 300) begin
            if (go) go_cnt++;
            if (n_o !== 4'(v.n)) n_bad++;
            busy_cnt++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
        chk({tag, "_go_pulses"}, go_cnt, 1);
        chk({tag, "_n_unstable"}, n_bad, 0);
        rd_chk(2'd2, 32'(v.exp_stat), {tag, "_status"});
        rd_chk(2'd3, v.exp_res, {tag, "_result"});
    endtask

    vec_t vecs[8];

    initial begin
        vec_t        rv;
        logic [31:0] last_res;
        int          busy_cnt, go_cnt, n_bad;

        // {n, lat, res, err_off, hang, exp_busy, exp_stat, exp_res}
        vecs[0] = '{5,  10, 32'd120,         -1, 0, 11, 3'b001, 32'd120};
        vecs[1] = '{13, 8,  32'h1234_5678,    2, 0, 9,  3'b011, 32'h1234_5678};
        vecs[2] = '{6,  10, 32'h0000_FFFF,   -1, 1, 65, 3'b101, 32'h1234_5678};
        vecs[3] = '{1,  1,  32'd1,           -1, 0, 2,  3'b001, 32'd1};
        vecs[4] = '{9,  64, 32'd362880,      -1, 0, 65, 3'b001, 32'd362880};
        vecs[5] = '{2,  63, 32'd2,           -1, 0, 64, 3'b001, 32'd2};
        vecs[6] = '{15, 5,  32'hABCD_0001,    0, 0, 6,  3'b011, 32'hABCD_0001};
        vecs[7] = '{7,  20, 32'h5555_5555,    3, 1, 65, 3'b101, 32'hABCD_0001};

        rst_n = 1'b0;
        we    = 1'b0;
        a     = 2'd0;
        wd    = '0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_go", 32'(go), 0);
        chk("rst_n_out", 32'(n_o), 0);
        rd_chk(2'd0, 0, "rst_rd_n");
        rd_chk(2'd1, 0, "rst_rd_ctrl");
        rd_chk(2'd2, 0, "rst_rd_status");
        rd_chk(2'd3, 0, "rst_rd_result");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
        end

        // STATUS W1C per bit (status is 3'b101 here)
        bus_write(2'd2, 32'd4);
        rd_chk(2'd2, 32'd1, "w1c_tmo");
        bus_write(2'd2, 32'd1);
        rd_chk(2'd2, 32'd0, "w1c_done");

        // RESULT is read-only
        @(posedge clk);
        #1;
        bus_write(2'd3, 32'hCAFE_F00D);
        rd_chk(2'd3, 32'hABCD_0001, "result_ro");

        // Done/Error while IDLE are ignored
        @(posedge clk);
        #1;
        man_done = 1'b1;
        man_err  = 1'b1;
        @(posedge clk);
        #1;
        man_done = 1'b0;
        man_err  = 1'b0;
        rd_chk(2'd2, 32'd0, "idle_done_ignored");
        rd_chk(2'd3, 32'hABCD_0001, "idle_result_kept");

        // GO and N=7 written mid-WAIT of an N=4 run
        @(posedge clk);
        #1;
        set_acc(10, 32'd24, -1, 0);
        bus_write(2'd0, 32'd4);
        bus_write(2'd1, 32'd1);
        busy_cnt = 0;
        go_cnt   = 0;
        n_bad    = 0;
        while (busy && busy_cnt < 300) begin
            if (go) go_cnt++;
            if (n_o !== 4'd4) n_bad++;
            if (busy_cnt == 3) begin we = 1'b1; a = 2'd0; wd = 32'd7; end
            if (busy_cnt == 4) begin a = 2'd1; wd = 32'd1; end
            if (busy_cnt == 5) begin we = 1'b0; wd = '0; end
            if (busy_cnt == 6) begin
                a = 2'd1;
                #1;
                chk("busy_read_ctrl", rd, 32'd1);
            end
            busy_cnt++;
            @(posedge clk);
            #1;
        end
        chk("midwr_busy_cycles", busy_cnt, 11);
        chk("midwr_go_pulses", go_cnt, 1);
        chk("midwr_n_unstable", n_bad, 0);
        rd_chk(2'd0, 32'd4, "midwr_n_reg");
        rd_chk(2'd2, 32'd1, "midwr_status");
        rd_chk(2'd3, 32'd24, "midwr_result");

        // W1C of done in the same cycle as Done capture: capture wins
        @(posedge clk);
        #1;
        set_acc(3, 32'd6, -1, 0);
        bus_write(2'd0, 32'd3);
        bus_write(2'd1, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        bus_write(2'd2, 32'd1);
        rd_chk(2'd2, 32'd1, "w1c_vs_capture");
        rd_chk(2'd3, 32'd6, "w1c_vs_capture_res");

        // Reset pulled low in WAIT
        @(posedge clk);
        #1;
        set_acc(20, 32'd99, -1, 0);
        bus_write(2'd0, 32'd9);
        bus_write(2'd1, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_go", 32'(go), 0);
        rd_chk(2'd2, 32'd0, "midrst_status");
        rd_chk(2'd0, 32'd0, "midrst_n_reg");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_txn(vecs[0], "after_rst");

        // Randomized transactions against the transaction-level model
        last_res = 32'd120;
        for (int k = 0; k < 10; k++) begin
            bit fired_err;
            @(posedge clk);
            #1;
            rv.n       = $urandom_range(0, 15);
            rv.lat     = $urandom_range(1, TIMEOUT_CYC);
            rv.res     = $urandom();
            rv.hang    = ($urandom_range(0, 4) == 0);
            rv.err_off = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rv.lat - 1) : -1;
            fired_err  = (rv.err_off >= 0);
            if (rv.hang) begin
                rv.exp_busy = 1 + TIMEOUT_CYC;
                rv.exp_stat = 3'b101;
                rv.exp_res  = last_res;
            end else begin
                rv.exp_busy = 1 + rv.lat;
                rv.exp_stat = {1'b0, fired_err, 1'b1};
                rv.exp_res  = rv.res;
            end
            last_res = rv.exp_res;
            run_txn(rv, $sformatf("rand%0d", k));
        end

`ifdef FACT_HOST_IRQ_EN
        // Interrupt: enable with GO, rises with done, drops after W1C
        @(posedge clk);
        #1;
        set_acc(4, 32'd6, -1, 0);
        bus_write(2'd0, 32'd3);
        bus_write(2'd1, 32'd3);
        chk("irq_low_busy", 32'(irq), 0);
        busy_cnt = 0;
        while (busy && busy_cnt < 300) begin
            busy_cnt++;
            @(posedge clk);
            #1;
        end
        chk("irq_busy_cycles", busy_cnt, 5);
        chk("irq_high", 32'(irq), 1);
        rd_chk(2'd1, 32'd2, "irq_ctrl_read");
        rd_chk(2'd3, 32'd6, "irq_result");
        @(posedge clk);
        #1;
        bus_write(2'd2, 32'd1);
        chk("irq_cleared", 32'(irq), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
